// File: rtl/lcd_responder_pkg.sv
// Shared constants, types and helpers for the HD44780-style LCD responder.
package lcd_responder_pkg;

  // DDRAM line bases and the last address of each line bank
  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE1_LAST = 7'h27;
  localparam logic [6:0] LINE2_LAST = 7'h67;

  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam int         NUM_CELLS  = 32;

  // Instruction opcode masks; an instruction is identified by its highest set bit
  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPLAY = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    I_NONE, I_CLEAR, I_HOME, I_ENTRY, I_DISP, I_SHIFT, I_FUNC, I_CGRAM, I_DDRAM
  } instr_e;

  function automatic instr_e decode_instr(input logic [7:0] d);
    if ((d & OP_DDRAM) != 8'h00)        return I_DDRAM;
    else if ((d & OP_CGRAM) != 8'h00)   return I_CGRAM;
    else if ((d & OP_FUNC) != 8'h00)    return I_FUNC;
    else if ((d & OP_SHIFT) != 8'h00)   return I_SHIFT;
    else if ((d & OP_DISPLAY) != 8'h00) return I_DISP;
    else if ((d & OP_ENTRY) != 8'h00)   return I_ENTRY;
    else if ((d & OP_HOME) != 8'h00)    return I_HOME;
    else if ((d & OP_CLEAR) != 8'h00)   return I_CLEAR;
    else                                return I_NONE;
  endfunction

  // Only the first 16 addresses of each line bank are visible cells
  function automatic logic cell_valid(input logic [6:0] a);
    return (a[5:4] == 2'b00);
  endfunction

  function automatic logic [4:0] cell_index(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

endpackage

// File: rtl/lcd_responder_if.sv
// Display bus between an HD44780 driver (master) and the responder (slave).
// Protocol: the master sets rs/rw/d_in, raises en, holds everything stable
// while en is high and for a few clk after en falls; the cycle completes on
// the falling edge of en as seen through the slave's synchronizer. On reads
// the slave drives d_out while d_oe is high and keeps it stable throughout.
interface lcd_responder_if;
  logic       en;
  logic       rs;
  logic       rw;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;

  modport master (output en, rs, rw, d_in, input d_out, d_oe);
  modport slave  (input en, rs, rw, d_in, output d_out, d_oe);
endinterface

// File: rtl/lcd_responder_ac_step.sv
// Address-counter step with wrap inside the two HD44780 line banks.
module lcd_ac_step
  import lcd_responder_pkg::*;
(
  input  logic [6:0] ac,
  input  logic       id,
  output logic [6:0] ac_next
);

  // Increment or decrement, jumping between bank ends instead of leaving them
  always_comb begin
    ac_next = ac;
    if (id) begin
      if (ac == LINE1_LAST)      ac_next = LINE2_BASE;
      else if (ac == LINE2_LAST) ac_next = LINE1_BASE;
      else                       ac_next = ac + 7'd1;
    end else begin
      if (ac == LINE2_BASE)      ac_next = LINE1_LAST;
      else if (ac == LINE1_BASE) ac_next = LINE2_LAST;
      else                       ac_next = ac - 7'd1;
    end
  end

endmodule

// File: rtl/lcd_responder.sv
// HD44780-compatible bus responder with a 2x16 DDRAM model and busy timing.
module lcd_responder
  import lcd_responder_pkg::*;
#(
  parameter int BUSY_SHORT = 2,
  parameter int BUSY_LONG  = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_responder_if.slave     bus,
  input  logic [4:0]         rd_addr,
  output logic [7:0]         rd_char,
  output logic               busy,
  output logic [6:0]         ac,
  output logic               disp_on,
  output logic               proto_err,
  output logic [1:0]         state_dbg
);

  localparam int CLR_CYCLES = (BUSY_LONG > NUM_CELLS) ? BUSY_LONG : NUM_CELLS;
  localparam int CW = 16;

  logic            en_s1_q, en_s2_q, en_prev_q;
  logic            rs_q, rs_d, rw_q, rw_d;
  logic [7:0]      d_q, d_d;
  logic [7:0]      d_out_q, d_out_d;
  logic [7:0]      mem_q [NUM_CELLS];
  logic [7:0]      mem_d [NUM_CELLS];
  logic [6:0]      ac_q, ac_d, ac_stepped;
  logic            id_q, id_d, disp_q, disp_d, err_q, err_d;
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_int, d_oe_int, fall, exec_wr, exec_rd, start_clear, step_id;
  instr_e          instr;

  assign fall        = en_prev_q & ~en_s2_q;
  assign d_oe_int    = en_s2_q & rw_q;
  assign instr       = decode_instr(d_q);
  assign exec_wr     = fall & ~rw_q & ~busy_int;
  assign exec_rd     = fall & rw_q & rs_q & ~busy_int;
  assign start_clear = exec_wr & ~rs_q & (instr == I_CLEAR);
  // Cursor shift picks its direction from the instruction, data access from I/D
  assign step_id     = (!rs_q && instr == I_SHIFT) ? d_q[2] : id_q;

  lcd_ac_step u_ac_step (.ac(ac_q), .id(step_id), .ac_next(ac_stepped));

  // Two-flop synchronizer for en plus a delayed copy for falling-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_s1_q   <= 1'b0;
      en_s2_q   <= 1'b0;
      en_prev_q <= 1'b0;
    end else begin
      en_s1_q   <= bus.en;
      en_s2_q   <= en_s1_q;
      en_prev_q <= en_s2_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: idle, short busy hold, or clear sweep with long hold
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (exec_wr || exec_rd) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CW'(BUSY_SHORT - 1)) state_d = ST_IDLE;
        else                              cnt_d   = cnt_q + CW'(1);
      end
      ST_CLEAR: begin
        if (cnt_q == CW'(CLR_CYCLES - 1)) state_d = ST_IDLE;
        else                              cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_int = (state_q != ST_IDLE);
  end

  // Datapath next values: bus capture, read data, instruction/data execution
  always_comb begin
    rs_d    = rs_q;
    rw_d    = 1'b0;
    d_d     = d_q;
    d_out_d = d_out_q;
    ac_d    = ac_q;
    id_d    = id_q;
    disp_d  = disp_q;
    err_d   = err_q;
    for (int i = 0; i < NUM_CELLS; i++) mem_d[i] = mem_q[i];

    // rw_q drops between cycles so d_oe cannot reuse a stale read flag
    if (en_s2_q) begin
      rs_d = bus.rs;
      rw_d = bus.rw;
      d_d  = bus.d_in;
    end

    // Read data is frozen once d_oe rises so it stays stable for the cycle
    if (en_s2_q && !d_oe_int) begin
      if (bus.rs) d_out_d = cell_valid(ac_q) ? mem_q[cell_index(ac_q)] : BLANK_CHAR;
      else        d_out_d = {busy_int, ac_q};
    end

    if (fall && !rw_q && busy_int) err_d = 1'b1;

    if (exec_rd) ac_d = ac_stepped;

    if (exec_wr) begin
      if (rs_q) begin
        if (cell_valid(ac_q)) mem_d[cell_index(ac_q)] = d_q;
        ac_d = ac_stepped;
      end else begin
        case (instr)
          I_CLEAR: begin
            ac_d = LINE1_BASE;
            id_d = 1'b1;
          end
          I_HOME:  ac_d = LINE1_BASE;
          I_ENTRY: begin
            id_d = d_q[1];
            if (d_q[0]) err_d = 1'b1;
          end
          I_DISP:  disp_d = d_q[2];
          I_SHIFT: ac_d = ac_stepped;
          I_FUNC:  if (!d_q[4] || !d_q[3]) err_d = 1'b1;
          I_DDRAM: ac_d = d_q[6:0];
          default: ;
        endcase
      end
    end

    // Clear blanks one cell per clk during the first cycles of the hold
    if (state_q == ST_CLEAR && cnt_q < CW'(NUM_CELLS)) mem_d[cnt_q[4:0]] = BLANK_CHAR;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      d_q     <= 8'h00;
      d_out_q <= 8'h00;
      ac_q    <= LINE1_BASE;
      id_q    <= 1'b1;
      disp_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_CELLS; i++) mem_q[i] <= BLANK_CHAR;
    end else begin
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      d_q     <= d_d;
      d_out_q <= d_out_d;
      ac_q    <= ac_d;
      id_q    <= id_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      for (int i = 0; i < NUM_CELLS; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign bus.d_out = d_out_q;
  assign bus.d_oe  = d_oe_int;
  assign rd_char   = mem_q[rd_addr];
  assign busy      = busy_int;
  assign ac        = ac_q;
  assign disp_on   = disp_q;
  assign proto_err = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: bus driver tasks, read-data scoreboard.
module tb_lcd_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic       busy;
  logic [6:0] ac;
  logic       disp_on;
  logic       proto_err;
  logic [1:0] state_dbg;

  int         n_vec = 0;
  int         n_err = 0;
  int         oe_leak = 0;
  bit         rd_window = 1'b0;
  logic [7:0] exp_q[$];

  lcd_responder_if bus ();

  lcd_responder #(.BUSY_SHORT(2), .BUSY_LONG(40)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .rd_addr(rd_addr), .rd_char(rd_char),
    .busy(busy), .ac(ac), .disp_on(disp_on), .proto_err(proto_err), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cell(input int idx, input logic [7:0] exp);
    rd_addr = idx[4:0];
    #1;
    check($sformatf("cell[%0d]", idx), rd_char, exp);
  endtask

  // one full bus cycle; signals held well past the synchronized falling edge
  task automatic bus_cycle(input logic r_s, input logic r_w, input logic [7:0] d, input bit rd);
    @(negedge clk);
    bus.rs   = r_s;
    bus.rw   = r_w;
    bus.d_in = d;
    if (rd) rd_window = 1'b1;
    bus.en = 1'b1;
    repeat (4) @(negedge clk);
    bus.en = 1'b0;
    repeat (5) @(negedge clk);
    rd_window = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_release", busy, 1'b0);
  endtask

  task automatic wr_instr(input logic [7:0] d);
    bus_cycle(1'b0, 1'b0, d, 1'b0);
    wait_idle();
  endtask

  task automatic wr_data(input logic [7:0] d);
    bus_cycle(1'b1, 1'b0, d, 1'b0);
    wait_idle();
  endtask

  task automatic rd_cycle(input logic r_s, input logic [7:0] exp);
    exp_q.push_back(exp);
    bus_cycle(r_s, 1'b1, 8'h00, 1'b1);
    check("d_oe_after_read", bus.d_oe, 1'b0);
    check("d_oe_outside_read", oe_leak, 0);
    wait_idle();
  endtask

  // monitor: captures read data while d_oe is high, checks stability, scores it
  initial begin
    logic [7:0] cur;
    logic [7:0] exp_v;
    bit         active;
    active = 1'b0;
    cur    = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        active = 1'b0;
      end else if (bus.d_oe) begin
        if (!rd_window) oe_leak++;
        if (!active) begin
          active = 1'b1;
          cur    = bus.d_out;
        end else begin
          n_vec++;
          if (bus.d_out !== cur) begin
            n_err++;
            $display("FAIL d_out_stable: got %02h held %02h", bus.d_out, cur);
          end
        end
      end else if (active) begin
        active = 1'b0;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL read_unexpected: got %02h required no read", cur);
        end else begin
          exp_v = exp_q.pop_front();
          if (cur !== exp_v) begin
            n_err++;
            $display("FAIL read_data: got %02h expected %02h", cur, exp_v);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    bus.en = 1'b0; bus.rs = 1'b0; bus.rw = 1'b0; bus.d_in = 8'h00;
    rd_addr = 5'd0;
    #22;
    // reset state
    check("rst_ac", ac, 7'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", proto_err, 1'b0);
    check("rst_disp", disp_on, 1'b0);
    check("rst_d_oe", bus.d_oe, 1'b0);
    check("rst_d_out", bus.d_out, 8'h00);
    for (int i = 0; i < 32; i++) check_cell(i, 8'h20);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // init sequence and "HI"
    wr_instr(8'h38);
    wr_instr(8'h0C);
    wr_instr(8'h06);
    wr_instr(8'h01);
    wr_data(8'h48);
    wr_data(8'h49);
    check_cell(0, 8'h48);
    check_cell(1, 8'h49);
    check_cell(2, 8'h20);
    check("hi_ac", ac, 7'h02);
    check("hi_disp", disp_on, 1'b1);
    check("hi_err", proto_err, 1'b0);

    // line 2 write
    wr_instr(8'hC0);
    check("l2_ac_set", ac, 7'h40);
    wr_data(8'h41);
    check_cell(16, 8'h41);
    check("l2_ac", ac, 7'h41);

    // wrap boundaries
    wr_instr(8'hA7);
    check("wrap_ac_set", ac, 7'h27);
    wr_data(8'h55);
    check("wrap_inc_ac", ac, 7'h40);
    check_cell(16, 8'h41);
    check_cell(7, 8'h20);
    wr_instr(8'h80);
    wr_instr(8'h04);
    wr_data(8'h33);
    check_cell(0, 8'h33);
    check("wrap_dec_ac", ac, 7'h67);
    wr_instr(8'h14);
    check("shift_inc_wrap", ac, 7'h00);
    wr_instr(8'hC0);
    wr_instr(8'h10);
    check("shift_dec_wrap", ac, 7'h27);

    // data and status reads
    wr_instr(8'h06);
    wr_instr(8'h85);
    wr_data(8'h5A);
    check_cell(5, 8'h5A);
    check("wr5_ac", ac, 7'h06);
    wr_instr(8'h85);
    rd_cycle(1'b1, 8'h5A);
    check("rd_ac", ac, 7'h06);
    rd_cycle(1'b0, 8'h06);
    check("status_ac", ac, 7'h06);
    wr_instr(8'h90);
    rd_cycle(1'b1, 8'h20);
    check("rd_off_ac", ac, 7'h11);

    // clear, status read while busy, write during busy
    bus_cycle(1'b0, 1'b0, 8'h01, 1'b0);
    exp_q.push_back(8'h80);
    bus_cycle(1'b0, 1'b1, 8'h00, 1'b1);
    bus_cycle(1'b1, 1'b0, 8'h77, 1'b0);
    check("clr_still_busy", busy, 1'b1);
    check("busy_wr_err", proto_err, 1'b1);
    wait_idle();
    check_cell(0, 8'h20);
    check_cell(1, 8'h20);
    check_cell(5, 8'h20);
    check_cell(16, 8'h20);
    check("clr_ac", ac, 7'h00);

    // reset in the middle of a clear
    wr_instr(8'hC4);
    wr_data(8'h99);
    check_cell(20, 8'h99);
    bus_cycle(1'b0, 1'b0, 8'h01, 1'b0);
    repeat (8) @(negedge clk);
    check("midclr_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_ac", ac, 7'h00);
    check("mrst_disp", disp_on, 1'b0);
    check("mrst_err", proto_err, 1'b0);
    check("mrst_d_out", bus.d_out, 8'h00);
    for (int i = 0; i < 32; i++) check_cell(i, 8'h20);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // first cycles after reset; function set with N=0 flags an error
    wr_data(8'h41);
    check_cell(0, 8'h41);
    check("post_rst_ac", ac, 7'h01);
    wr_instr(8'h38);
    check("fs_ok_err", proto_err, 1'b0);
    wr_instr(8'h30);
    check("fs_n0_err", proto_err, 1'b1);

    repeat (4) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_responder.md
LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 Parameter BUSY_SHORT, default 2, busy-hold cycles after any write or instruction except clear.
REQ-002 Parameter BUSY_LONG, default 40, minimum busy-hold cycles after clear display; must be >= 32.
REQ-003 clk  input  1  system clock; one clock only.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  HD44780 enable strobe from the display driver; asynchronous to clk.
REQ-006 rs  input  1  register select: 0 = instruction/status, 1 = data.
REQ-007 rw  input  1  0 = write to responder, 1 = read from responder.
REQ-008 d_in  input  8  bus data driven by the driver.
REQ-009 d_out  output  8  bus data returned on read cycles.
REQ-010 d_oe  output  1  high while the responder drives d_out.
REQ-011 rd_addr  input  5  checker port: cell index 0-15 = line 1, 16-31 = line 2.
REQ-012 rd_char  output  8  DDRAM content at rd_addr, combinational.
REQ-013 busy  output  1  busy flag.
REQ-014 ac  output  7  address counter.
REQ-015 disp_on  output  1  display-on bit (D of the display-control instruction).
REQ-016 proto_err  output  1  sticky error flag.

Function
REQ-017 en SHALL pass through a 2-flop synchronizer; a bus cycle ends on the clk cycle in which the synchronized en falls.
REQ-018 rs, rw and d_in SHALL be registered on every clk in which synchronized en is high; the value captured last is used at the falling edge.
REQ-019 A write takes effect one clk after the falling edge is detected; busy SHALL rise in that same clk.
REQ-020 Instruction decode by highest set bit of d_in:
- 0x01 clear: all 32 cells = 0x20, one cell per clk; ac = 0; I/D = 1; busy for max(32, BUSY_LONG).
- 0x02/0x03 home: ac = 0.
- 0x04-0x07 entry mode: store I/D = bit1; S = bit0 not supported; S = 1 sets proto_err.
- 0x08-0x0F display control: disp_on = bit2; cursor and blink bits ignored.
- 0x10-0x1F shift: ac +/-1 per bit2, as for a data access.
- 0x20-0x3F function set: accepted; DL = 0 or N = 0 sets proto_err.
- 0x40-0x7F CGRAM address: ignored.
- 0x80-0xFF DDRAM address: ac = d_in[6:0].
REQ-021 Data write (rs = 1): if ac is in 0x00-0x0F or 0x40-0x4F, store d_in at cell (ac[6] ? 16 : 0) + ac[3:0]; otherwise discard; ac then steps per I/D.
REQ-022 ac stepping SHALL wrap within the two HD44780 line banks:
- increment: 0x27 -> 0x40, 0x67 -> 0x00;
- decrement: 0x40 -> 0x27, 0x00 -> 0x67.
REQ-023 A write ending while busy = 1 SHALL be ignored and SHALL set proto_err.
REQ-024 Status read (rs = 0, rw = 1): d_out = {busy, ac}; no state change.
REQ-025 Data read (rs = 1, rw = 1): d_out = cell at ac, or 0x20 if ac is off-screen; ac steps at the falling edge; busy holds BUSY_SHORT cycles.
REQ-026 d_oe = synchronized en AND registered rw; d_out SHALL be stable for the whole time d_oe is high.
REQ-027 A falling edge of en arriving while a clear is in progress SHALL be treated as a write during busy (REQ-023).
REQ-028 rd_char SHALL reflect a data write on the clk after that write executes.

Reset
REQ-029 While rst_n = 0, regardless of clk:
- all 32 cells = 0x20;
- ac = 0, I/D = 1, disp_on = 0;
- busy = 0, proto_err = 0;
- d_oe = 0, d_out = 0;
- synchronizer flops = 0.
REQ-030 Reset asserted mid-clear or mid-cycle SHALL abort the operation with no partial state kept; the first bus cycle is accepted after the synchronizer refills.

Structure
REQ-031 A shared package SHALL hold instruction opcode masks, the line base addresses 0x00/0x40, the wrap limits 0x27/0x67 and the blank character 0x20.
REQ-032 The address-counter step/wrap logic SHALL be a sub-module, lcd_ac_step: inputs ac and I/D; output next ac; combinational.

Verification
REQ-033 Reset, write 0x38, 0x0C, 0x06, 0x01, then "HI" -> rd_char[0] = 0x48, rd_char[1] = 0x49, ac = 0x02, disp_on = 1.
REQ-034 Write 0xC0, then data 0x41 -> cell 16 = 0x41, ac = 0x41.
REQ-035 Set ac = 0x27 with I/D = 1, write data -> data discarded, ac = 0x40; set ac = 0x00 with I/D = 0, write data -> ac = 0x67.
REQ-036 Issue clear, then a status read within 10 clk -> d_out[7] = 1; a write during busy leaves cells unchanged and sets proto_err = 1.
REQ-037 Write 0x5A at cell 5, set ac = 0x05, data read -> d_out = 0x5A, ac = 0x06, d_oe high only while en is high.
REQ-038 Assert rst_n low during a clear at cell 10 -> all cells = 0x20, busy = 0, ac = 0 immediately.
